// File: rtl/dip_switch_debouncer_pkg.sv
// Shared constants for the DIP/switch debouncer.
//   DIP_WIDTH    - width of the DIP word carried in each frame
//   SWITCH_WIDTH - number of push switches carried in each frame
//   FRAME_BITS   - total payload bits per deserialised frame
//   cnt_width()  - width of a match counter able to hold 0..n
package dip_switch_debouncer_pkg;

    localparam int unsigned DIP_WIDTH    = 16;
    localparam int unsigned SWITCH_WIDTH = 5;
    localparam int unsigned FRAME_BITS   = DIP_WIDTH + SWITCH_WIDTH;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dip_debounce_cell.sv
// One debounce cell: a value is committed to stable_o only after STABLE_FRAMES
// consecutive identical samples.
//   clk_i         - system clock
//   rst_i         - synchronous active-high reset
//   sample_en_i   - frame strobe; sample_i is only looked at in this cycle
//   clear_cnt_i   - discard the running match count (link timeout)
//   sample_i      - raw value from the current frame
//   stable_o      - registered debounced value
//   stable_next_o - value stable_o takes at the next edge
//   commit_o      - stable_o changes at the next edge
module dip_debounce_cell
    import dip_switch_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned STABLE_FRAMES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_en_i,
    input  logic             clear_cnt_i,
    input  logic [WIDTH-1:0] sample_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] stable_next_o,
    output logic             commit_o
);

    localparam int unsigned     CntW   = cnt_width(STABLE_FRAMES);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_FRAMES);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_o = 1'b0;
        if (sample_en_i) begin
            if (sample_i != cand_q) begin
                cand_d = sample_i;
                cnt_d  = CntW'(1);
            end else if (cnt_q < CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Re-confirming the value already held is not a commit.
            commit_o = (cnt_d >= CntMax) && (sample_i != stable_o);
        end else if (clear_cnt_i) begin
            cnt_d = '0;
        end
        stable_next_o = commit_o ? sample_i : stable_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_o <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_o <= stable_next_o;
        end
    end

endmodule

// File: rtl/dip_switch_debouncer.sv
// Debounces frames from the DIP/switch deserialiser.
//   i_CLK, i_RESET  - clock, synchronous active-high reset
//   i_DIP16         - raw DIP word
//   i_Switch5       - raw switch bits
//   i_DIPLatch      - frame latch; each rising edge marks one frame
//   o_DIP16         - debounced DIP word
//   o_Switch5       - debounced switch levels
//   o_SwitchRise5   - one-cycle press pulse per switch
//   o_SwitchFall5   - one-cycle release pulse per switch
//   o_DIPChanged    - one-cycle pulse when o_DIP16 changes
//   o_LinkLost      - no frame for TIMEOUT_CYCLES clocks
module dip_switch_debouncer
    import dip_switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET,
    input  logic [DIP_WIDTH-1:0]    i_DIP16,
    input  logic [SWITCH_WIDTH-1:0] i_Switch5,
    input  logic                    i_DIPLatch,
    output logic [DIP_WIDTH-1:0]    o_DIP16,
    output logic [SWITCH_WIDTH-1:0] o_Switch5,
    output logic [SWITCH_WIDTH-1:0] o_SwitchRise5,
    output logic [SWITCH_WIDTH-1:0] o_SwitchFall5,
    output logic                    o_DIPChanged,
    output logic                    o_LinkLost
);

    localparam int unsigned      TCntW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TCntW-1:0] TMax  = TCntW'(TIMEOUT_CYCLES);

    logic                    latch_q;
    logic                    fs;
    logic                    expire;
    logic [TCntW-1:0]        tcnt_q, tcnt_d;
    logic                    link_lost_d;
    logic [FRAME_BITS-1:0]   frame;

    logic [DIP_WIDTH-1:0]    dip_stable_q, dip_stable_d;
    logic                    dip_commit;
    logic [SWITCH_WIDTH-1:0] sw_stable_q, sw_stable_d, sw_commit;

    logic [SWITCH_WIDTH-1:0] rise_d, fall_d;
    logic                    changed_d;

    assign frame = {i_Switch5, i_DIP16};

    // A latch held high is a single frame: only its rising edge counts.
    assign fs     = i_DIPLatch & ~latch_q;
    // Fires once, on the edge where the idle count reaches the limit; fs wins.
    assign expire = ~fs & (tcnt_q == TMax - 1'b1);

    dip_debounce_cell #(
        .WIDTH         (DIP_WIDTH),
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_dip_cell (
        .clk_i         (i_CLK),
        .rst_i         (i_RESET),
        .sample_en_i   (fs),
        .clear_cnt_i   (expire),
        .sample_i      (frame[DIP_WIDTH-1:0]),
        .stable_o      (dip_stable_q),
        .stable_next_o (dip_stable_d),
        .commit_o      (dip_commit)
    );

    for (genvar i = 0; i < SWITCH_WIDTH; i++) begin : g_sw_cell
        dip_debounce_cell #(
            .WIDTH         (1),
            .STABLE_FRAMES (STABLE_FRAMES)
        ) u_sw_cell (
            .clk_i         (i_CLK),
            .rst_i         (i_RESET),
            .sample_en_i   (fs),
            .clear_cnt_i   (expire),
            .sample_i      (frame[DIP_WIDTH+i]),
            .stable_o      (sw_stable_q[i]),
            .stable_next_o (sw_stable_d[i]),
            .commit_o      (sw_commit[i])
        );
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (fs) begin
            tcnt_d = '0;
        end else if (tcnt_q < TMax) begin
            tcnt_d = tcnt_q + 1'b1;
        end
        link_lost_d = o_LinkLost;
        if (fs) begin
            link_lost_d = 1'b0;
        end else if (expire) begin
            link_lost_d = 1'b1;
        end
        rise_d    = sw_commit & sw_stable_d & ~sw_stable_q;
        fall_d    = sw_commit & ~sw_stable_d & sw_stable_q;
        changed_d = dip_commit & (dip_stable_d != dip_stable_q);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            latch_q       <= 1'b0;
            tcnt_q        <= '0;
            o_LinkLost    <= 1'b0;
            o_SwitchRise5 <= '0;
            o_SwitchFall5 <= '0;
            o_DIPChanged  <= 1'b0;
        end else begin
            latch_q       <= i_DIPLatch;
            tcnt_q        <= tcnt_d;
            o_LinkLost    <= link_lost_d;
            o_SwitchRise5 <= rise_d;
            o_SwitchFall5 <= fall_d;
            o_DIPChanged  <= changed_d;
        end
    end

    assign o_DIP16   = dip_stable_q;
    assign o_Switch5 = sw_stable_q;

endmodule

// File: tb/tb_dip_switch_debouncer.sv
module tb_dip_switch_debouncer;

    localparam int unsigned S = 4;
    localparam int unsigned T = 256;

    logic        clk = 1'b0;
    logic        i_RESET = 1'b1;
    logic [15:0] i_DIP16 = '0;
    logic [4:0]  i_Switch5 = '0;
    logic        i_DIPLatch = 1'b0;
    logic [15:0] o_DIP16;
    logic [4:0]  o_Switch5, o_SwitchRise5, o_SwitchFall5;
    logic        o_DIPChanged, o_LinkLost;

    dip_switch_debouncer #(
        .STABLE_FRAMES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (i_RESET),
        .i_DIP16       (i_DIP16),
        .i_Switch5     (i_Switch5),
        .i_DIPLatch    (i_DIPLatch),
        .o_DIP16       (o_DIP16),
        .o_Switch5     (o_Switch5),
        .o_SwitchRise5 (o_SwitchRise5),
        .o_SwitchFall5 (o_SwitchFall5),
        .o_DIPChanged  (o_DIPChanged),
        .o_LinkLost    (o_LinkLost)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output snapshot, due in the cycle after the edge stamped in cyc.
    typedef struct {
        int unsigned cyc;
        logic [15:0] dip;
        logic [4:0]  sw;
        logic [4:0]  rise;
        logic [4:0]  fall;
        logic        changed;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_on = 0;

    // Reference model: recent samples per cell since the last timeout/reset.
    logic [15:0] dip_hist[$];
    logic        sw_hist[5][$];
    logic [15:0] st_dip = '0;
    logic [4:0]  st_sw = '0;
    int unsigned last_fs = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_frame(input int unsigned fe, input logic [15:0] d, input logic [4:0] s);
        exp_t e;
        bit   all_eq;
        if (fe - last_fs - 1 >= T) begin
            dip_hist.delete();
            for (int i = 0; i < 5; i++) sw_hist[i].delete();
        end
        last_fs = fe;
        e.cyc = fe;
        e.changed = 1'b0;
        e.rise = '0;
        e.fall = '0;
        dip_hist.push_back(d);
        if (dip_hist.size() > S) void'(dip_hist.pop_front());
        all_eq = (dip_hist.size() == S);
        foreach (dip_hist[k]) if (dip_hist[k] != d) all_eq = 0;
        if (all_eq && d != st_dip) begin
            st_dip = d;
            e.changed = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            sw_hist[i].push_back(s[i]);
            if (sw_hist[i].size() > S) void'(sw_hist[i].pop_front());
            all_eq = (sw_hist[i].size() == S);
            foreach (sw_hist[i][k]) if (sw_hist[i][k] != s[i]) all_eq = 0;
            if (all_eq && s[i] != st_sw[i]) begin
                st_sw[i] = s[i];
                if (s[i]) e.rise[i] = 1'b1;
                else e.fall[i] = 1'b1;
            end
        end
        e.dip = st_dip;
        e.sw = st_sw;
        if (e.changed || e.rise != 0 || e.fall != 0) exp_q.push_back(e);
    endtask

    // Called at posedge+1; data is scrambled outside the fs cycle since it must be ignored.
    task automatic frame(input logic [15:0] d, input logic [4:0] s, input int hold, input int gap);
        model_frame(cyc + 1, d, s);
        i_DIPLatch = 1'b1;
        i_DIP16 = d;
        i_Switch5 = s;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            i_DIP16 = 16'($urandom);
            i_Switch5 = 5'($urandom);
        end
        i_DIPLatch = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk); #1;
            i_DIP16 = 16'($urandom);
            i_Switch5 = 5'($urandom);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        e.cyc = cyc + 1;
        e.dip = '0;
        e.sw = '0;
        e.rise = '0;
        e.fall = '0;
        e.changed = 1'b0;
        exp_q.push_back(e);
        dip_hist.delete();
        for (int i = 0; i < 5; i++) sw_hist[i].delete();
        st_dip = '0;
        st_sw = '0;
        last_fs = cyc + 1;
        i_DIPLatch = 1'b0;
        i_RESET = 1'b1;
        @(posedge clk); #1;
        i_RESET = 1'b0;
    endtask

    // Monitor: pops an expectation on its due cycle, otherwise requires quiet, held outputs.
    logic [15:0] shown_dip = '0;
    logic [4:0]  shown_sw = '0;
    exp_t        me;
    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                me = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missed_event: due cycle %0d not observed (now %0d)", me.cyc, cyc);
            end
            n_vec++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                me = exp_q.pop_front();
                if (o_DIP16 !== me.dip || o_Switch5 !== me.sw || o_SwitchRise5 !== me.rise ||
                    o_SwitchFall5 !== me.fall || o_DIPChanged !== me.changed) begin
                    n_bad++;
                    $display("FAIL event@%0d: got dip=%h sw=%b rise=%b fall=%b chg=%b expected dip=%h sw=%b rise=%b fall=%b chg=%b",
                             cyc, o_DIP16, o_Switch5, o_SwitchRise5, o_SwitchFall5, o_DIPChanged,
                             me.dip, me.sw, me.rise, me.fall, me.changed);
                end
                shown_dip = me.dip;
                shown_sw = me.sw;
            end else if (o_SwitchRise5 !== 5'b0 || o_SwitchFall5 !== 5'b0 ||
                         o_DIPChanged !== 1'b0 || o_DIP16 !== shown_dip ||
                         o_Switch5 !== shown_sw) begin
                n_bad++;
                $display("FAIL steady@%0d: got dip=%h sw=%b rise=%b fall=%b chg=%b expected dip=%h sw=%b no pulses",
                         cyc, o_DIP16, o_Switch5, o_SwitchRise5, o_SwitchFall5, o_DIPChanged,
                         shown_dip, shown_sw);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned target;
        logic [15:0] rd;
        logic [4:0]  rs;
        logic [15:0] dip_set[3];

        repeat (3) @(posedge clk);
        #1;
        mon_on = 1;
        do_reset();
        @(negedge clk);
        chk("reset_dip", 32'(o_DIP16), 32'h0);
        chk("reset_sw", 32'(o_Switch5), 32'h0);
        chk("reset_linklost", 32'(o_LinkLost), 32'h0);
        @(posedge clk); #1;

        // Basic commit after four matching frames.
        repeat (4) frame(16'hA5C3, 5'b00101, 1, 2);
        // Bounce on the DIP word.
        frame(16'h1234, 5'b00101, 1, 2);
        frame(16'h1234, 5'b00101, 1, 2);
        frame(16'hFFFF, 5'b00101, 1, 2);
        repeat (3) frame(16'h1234, 5'b00101, 1, 2);
        // Switch release.
        repeat (4) frame(16'h1234, 5'b00001, 1, 2);
        repeat (4) frame(16'h1234, 5'b00000, 1, 2);
        // Long latch counts as one frame.
        frame(16'h5A5A, 5'b11000, 30, 2);
        repeat (3) frame(16'h5A5A, 5'b11000, 1, 2);

        // Link loss.
        frame(16'h5A5A, 5'b11000, 1, 2);
        target = last_fs + T;
        while (cyc < target - 1) @(negedge clk);
        chk("linklost_before_limit", 32'(o_LinkLost), 32'h0);
        @(negedge clk);
        chk("linklost_at_limit", 32'(o_LinkLost), 32'h1);
        repeat (5) @(negedge clk);
        chk("linklost_held", 32'(o_LinkLost), 32'h1);
        chk("dip_held_after_loss", 32'(o_DIP16), 32'h5A5A);
        @(posedge clk); #1;
        frame(16'h0F0F, 5'b00110, 1, 2);
        @(negedge clk);
        chk("linklost_cleared", 32'(o_LinkLost), 32'h0);
        @(posedge clk); #1;
        repeat (3) frame(16'h0F0F, 5'b00110, 1, 2);

        // Reset between frames 3 and 4 of a new value.
        repeat (3) frame(16'h0BEE, 5'b10010, 1, 2);
        do_reset();
        @(negedge clk);
        chk("midrun_reset_dip", 32'(o_DIP16), 32'h0);
        chk("midrun_reset_sw", 32'(o_Switch5), 32'h0);
        @(posedge clk); #1;
        repeat (4) frame(16'h0BEE, 5'b10010, 1, 2);

        // Randomized traffic.
        dip_set[0] = 16'h0BEE;
        dip_set[1] = 16'hC0DE;
        dip_set[2] = 16'h7001;
        rd = 16'h0BEE;
        rs = 5'b10010;
        for (int it = 0; it < 350; it++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 5) begin
                repeat ($urandom_range(T - 4, T + 30)) begin
                    @(posedge clk); #1;
                end
            end else begin
                if ($urandom_range(0, 99) < 25) rd = dip_set[$urandom_range(0, 2)];
                for (int b = 0; b < 5; b++)
                    if ($urandom_range(0, 99) < 12) rs[b] = ~rs[b];
                frame(rd, rs, $urandom_range(1, 3), $urandom_range(1, 4));
            end
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
